// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation against a synchronous program
// memory, with a one-entry hold buffer for downstream stalls and redirect support.
module fetch_unit #(
    parameter int unsigned             ADDR_WIDTH = 10,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    state_t                state;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight_vld;
    logic [DATA_WIDTH-1:0] hold_instr;
    logic [ADDR_WIDTH-1:0] hold_pc;

    assign imem_addr = req_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            req_pc       <= RESET_PC;
            inflight_pc  <= '0;
            inflight_vld <= 1'b0;
            hold_instr   <= '0;
            hold_pc      <= '0;
        end else if (redirect_valid) begin
            state        <= FETCH;
            req_pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            inflight_vld <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall || !inflight_vld) begin
                        inflight_pc  <= req_pc;
                        inflight_vld <= 1'b1;
                        req_pc       <= req_pc + PC_STEP;
                    end else begin
                        // Park the presented word; req_pc stays so memory re-reads the successor.
                        hold_instr   <= imem_data;
                        hold_pc      <= inflight_pc;
                        inflight_vld <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inflight_pc  <= req_pc;
                        inflight_vld <= 1'b1;
                        req_pc       <= req_pc + PC_STEP;
                        state        <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (state == HOLD) begin
            instr_valid = 1'b1;
            instr       = hold_instr;
            instr_pc    = hold_pc;
        end else if (inflight_vld) begin
            instr_valid = 1'b1;
            instr       = imem_data;
            instr_pc    = inflight_pc;
        end
    end

endmodule
